crypt_seq: RTL and testbench
============================

CRYPT_SEQ -- requirements
Module: crypt_seq

Interface
REQ-001 Parameter: none; frame length is a runtime input.
REQ-002 Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high; clears all state.
REQ-005 cfg_key  in  8  key byte; sampled on an accepted start.
REQ-006 cfg_mode  in  1  1 = encrypt, 0 = decrypt; sampled on an accepted start.
REQ-007 cfg_len  in  4  frame length in bytes; 0 encodes 16; sampled on an accepted start.
REQ-008 start  in  1  single-cycle frame request.
REQ-009 abort  in  1  terminates the current frame.
REQ-010 busy  out  1  high from an accepted start until done or abort.
REQ-011 done  out  1  one-cycle pulse at frame completion.
REQ-012 in_valid, in_data[7:0] in; in_ready out  input byte stream with valid/ready handshake.
REQ-013 out_valid, out_data[7:0] out; out_ready in  output byte stream with valid/ready handshake.
REQ-014 dp_sel  out  1  drives the encrypt/decrypt select of the external datapath; equals the latched mode.
REQ-015 dp_key  out  8  latched key.
REQ-016 dp_inp  out  8  stage-1 data register.
REQ-017 dp_out  in  8  combinational datapath result for dp_inp, dp_key and dp_sel.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, FLUSH.
- IDLE -> RUN on start=1 and abort=0.
- RUN -> FLUSH when the last input byte is accepted.
- FLUSH -> IDLE on the last output handshake.
REQ-019 An accepted start SHALL latch cfg_key, cfg_mode and cfg_len, and clear the in/out byte counters.
- start is ignored when not in IDLE.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 dp_key and dp_sel SHALL be stable for the whole frame; cfg_* changes while busy have no effect.
REQ-022 Stage 1 (dp_inp, s1_valid) and stage 2 (out_data, out_valid) SHALL form a two-register pipeline.
- out_data captures dp_out.
REQ-023 s1 advance condition: s1_valid && (!out_valid || out_ready).
REQ-024 in_ready SHALL equal (state==RUN) && (in_cnt < len) && (!s1_valid || s1 advance); it is combinational.
REQ-025 Latency: a byte accepted at edge N SHALL appear on out_data with out_valid=1 after edge N+1 when out_ready is held high.
- Sustained throughput is one byte per cycle.
REQ-026 out_valid SHALL stay high and out_data stable until the out handshake completes.
REQ-027 in_cnt and out_cnt SHALL be 5-bit counters.
- The last input byte is the one where in_cnt reaches len.
- The last output byte is the one where out_cnt reaches len.
- len = 16 when cfg_len = 0; counters never wrap within a frame.
REQ-028 done SHALL pulse high for exactly one cycle, on the cycle after the last output handshake; the FSM returns to IDLE in that same cycle.
REQ-029 abort=1 in RUN or FLUSH SHALL, at the next edge:
- go to IDLE;
- clear s1_valid, out_valid and the counters;
- not assert done.
REQ-030 abort in IDLE SHALL have no effect; abort takes priority over start.
REQ-031 When a start and a done occur on adjacent cycles, the start SHALL be accepted the cycle after done.
REQ-032 Bytes presented while in_ready=0 SHALL not be consumed and SHALL not be dropped.

Reset
REQ-033 On rst=1, the block SHALL immediately enter IDLE with all outputs cleared:
- busy=0, done=0, in_ready=0, out_valid=0;
- out_data=0, dp_inp=0, dp_key=0, dp_sel=0;
- counters cleared.
REQ-034 rst asserted mid-frame SHALL discard all in-flight bytes; no done pulse follows.

Verification
REQ-035 Basic frame: start with cfg_len=3, cfg_mode=1, cfg_key=8'hA5; inputs 11, 22, 33 back-to-back; out_ready=1; model dp_out = dp_inp^dp_key.
- Required: outputs B4, 87, 96; first output one cycle after its input accept; done one cycle after the 3rd out handshake.
REQ-036 Backpressure: cfg_len=4, out_ready=0 for 5 cycles after the first byte.
- Required: in_ready drops once both stages are full; no byte is lost or duplicated; order is preserved.
REQ-037 Length 0: cfg_len=0.
- Required: exactly 16 bytes in and 16 out, then a single done pulse; the 17th in_valid sees in_ready=0.
REQ-038 Abort: abort asserted after 2 of 5 bytes are accepted.
- Required: next cycle busy=0, out_valid=0, no done.
- A new start with cfg_key=8'h0F then processes correctly with the new key.
REQ-039 Async reset: rst pulsed between clock edges mid-frame.
- Required: outputs clear without waiting for a clock edge; start is accepted afterwards.
REQ-040 Config freeze: cfg_key changed to 8'hFF mid-frame.
- Required: dp_key keeps the start-time value until the frame ends.

Source files
------------

// File: rtl/crypt_seq.sv
// crypt_seq: frame sequencer for an external byte-wide crypt datapath.
// Latches key/mode/length on start and streams bytes through a two-stage
// valid/ready pipeline. Stage 1 feeds the datapath and stage 2 captures
// its result.
module crypt_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cfg_key,
  input  logic       cfg_mode,
  input  logic [3:0] cfg_len,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       dp_sel,
  output logic [7:0] dp_key,
  output logic [7:0] dp_inp,
  input  logic [7:0] dp_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic       mode_q, mode_d;
  logic [4:0] len_q, len_d;
  logic [4:0] in_cnt_q, in_cnt_d;
  logic [4:0] out_cnt_q, out_cnt_d;
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] dp_inp_q, dp_inp_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       done_q, done_d;

  logic       s1_adv_s;
  logic       in_ready_s;
  logic       in_fire_s;
  logic       out_fire_s;
  logic       in_last_s;
  logic       out_last_s;
  logic       abort_s;

  // Handshake qualifiers; the counters are 5 bits so len=16 and the +1 compare never wrap.
  always_comb begin
    s1_adv_s   = s1_valid_q && (!out_valid_q || out_ready);
    in_ready_s = (state_q == ST_RUN) && (in_cnt_q < len_q) && (!s1_valid_q || s1_adv_s);
    in_fire_s  = in_valid && in_ready_s;
    out_fire_s = out_valid_q && out_ready;
    in_last_s  = in_fire_s && ((in_cnt_q + 5'd1) == len_q);
    out_last_s = out_fire_s && ((out_cnt_q + 5'd1) == len_q);
    abort_s    = abort && (state_q != ST_IDLE);
  end

  // Next-state for FSM, configuration latch and both pipeline stages.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    mode_d      = mode_q;
    len_d       = len_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    s1_valid_d  = s1_valid_q;
    dp_inp_d    = dp_inp_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    if (abort_s) begin
      // Abort drops everything in flight and returns silently to idle.
      state_d     = ST_IDLE;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      in_cnt_d    = 5'd0;
      out_cnt_d   = 5'd0;
    end else begin
      // Stage 1: load on input accept, empty when it hands off to stage 2.
      if (in_fire_s) begin
        s1_valid_d = 1'b1;
        dp_inp_d   = in_data;
        in_cnt_d   = in_cnt_q + 5'd1;
      end else if (s1_adv_s) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end

      // Stage 2: capture the datapath result; hold until the consumer takes it.
      if (s1_adv_s) begin
        out_valid_d = 1'b1;
        out_data_d  = dp_out;
      end else if (out_fire_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end

      if (out_fire_s) begin
        out_cnt_d = out_cnt_q + 5'd1;
      end else begin
        out_cnt_d = out_cnt_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d   = ST_RUN;
            key_d     = cfg_key;
            mode_d    = cfg_mode;
            len_d     = (cfg_len == 4'd0) ? 5'd16 : {1'b0, cfg_len};
            in_cnt_d  = 5'd0;
            out_cnt_d = 5'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (in_last_s) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (out_last_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          s1_valid_d  = 1'b0;
          out_valid_d = 1'b0;
          in_cnt_d    = 5'd0;
          out_cnt_d   = 5'd0;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= 8'd0;
      mode_q      <= 1'b0;
      len_q       <= 5'd0;
      in_cnt_q    <= 5'd0;
      out_cnt_q   <= 5'd0;
      s1_valid_q  <= 1'b0;
      dp_inp_q    <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      s1_valid_q  <= s1_valid_d;
      dp_inp_q    <= dp_inp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dp_sel    = mode_q;
  assign dp_key    = key_q;
  assign dp_inp    = dp_inp_q;

endmodule

// File: tb/tb_crypt_seq.sv
// Directed bench for crypt_seq with an XOR datapath model.
module tb_crypt_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_key;
  logic       cfg_mode;
  logic [3:0] cfg_len;
  logic       start, abort;
  logic       busy, done;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       dp_sel;
  logic [7:0] dp_key, dp_inp, dp_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  int         in_cyc[$];
  int         out_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = -1;

  crypt_seq dut (
    .clk(clk), .rst(rst), .cfg_key(cfg_key), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .dp_sel(dp_sel), .dp_key(dp_key), .dp_inp(dp_inp), .dp_out(dp_out)
  );

  // External datapath model.
  assign dp_out = dp_inp ^ dp_key;

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record handshakes and done pulses on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin in_q.push_back(in_data); in_cyc.push_back(cyc); end
      if (out_valid && out_ready) begin out_q.push_back(out_data); out_cyc.push_back(cyc); end
      if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    end
  end

  function automatic logic [7:0] out_at(input int i);
    if (i < out_q.size()) return out_q[i];
    else return 8'hxx;
  endfunction

  function automatic int out_cyc_at(input int i);
    if (i < out_cyc.size()) return out_cyc[i];
    else return -1000;
  endfunction

  function automatic int in_cyc_at(input int i);
    if (i < in_cyc.size()) return in_cyc[i];
    else return -1000;
  endfunction

  task automatic start_frame(input logic [7:0] k, input logic m, input logic [3:0] l);
    cfg_key = k; cfg_mode = m; cfg_len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    int t;
    in_valid = 1'b1; in_data = b; t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL feed_timeout: byte %h never accepted, in_ready=%b want 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin @(negedge clk); t++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    checks++; if (dp_inp !== 8'h00) begin errors++; $display("FAIL rst_dp_inp: got %h want 00", dp_inp); end
    checks++; if (dp_key !== 8'h00) begin errors++; $display("FAIL rst_dp_key: got %h want 00", dp_key); end
    checks++; if (dp_sel !== 1'b0) begin errors++; $display("FAIL rst_dp_sel: got %b want 0", dp_sel); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    int ib, ob, db;
    logic [7:0] exp_v [3];
    exp_v = '{8'hB4, 8'h87, 8'h96};
    ib = in_q.size(); ob = out_q.size(); db = done_cnt;
    out_ready = 1'b1;
    start_frame(8'hA5, 1'b1, 4'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    checks++; if (dp_key !== 8'hA5) begin errors++; $display("FAIL basic_dp_key: got %h want a5", dp_key); end
    checks++; if (dp_sel !== 1'b1) begin errors++; $display("FAIL basic_dp_sel: got %b want 1", dp_sel); end
    feed_byte(8'h11); feed_byte(8'h22); feed_byte(8'h33);
    wait_idle();
    checks++; if (out_q.size() - ob !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", out_q.size() - ob); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_at(ob + i) !== exp_v[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, out_at(ob + i), exp_v[i]); end
    end
    checks++;
    if (out_cyc_at(ob) - in_cyc_at(ib) !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", out_cyc_at(ob) - in_cyc_at(ib)); end
    checks++;
    if (in_cyc_at(ib + 2) - in_cyc_at(ib) !== 2) begin errors++; $display("FAIL basic_in_rate: got %0d want 2", in_cyc_at(ib + 2) - in_cyc_at(ib)); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - db); end
    checks++;
    if (done_cyc !== out_cyc_at(ob + 2) + 1) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, out_cyc_at(ob + 2) + 1); end
  endtask

  task automatic test_backpressure();
    int ib, ob;
    logic [7:0] exp_v [4];
    exp_v = '{8'h3D, 8'h3E, 8'h3F, 8'h38};
    ib = in_q.size(); ob = out_q.size();
    out_ready = 1'b0;
    start_frame(8'h3C, 1'b0, 4'd4);
    fork
      begin
        feed_byte(8'h01); feed_byte(8'h02); feed_byte(8'h03); feed_byte(8'h04);
      end
      begin
        repeat (4) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 8'h3D) begin errors++; $display("FAIL bp_out_hold: got %h want 3d", out_data); end
        checks++; if (dp_inp !== 8'h02) begin errors++; $display("FAIL bp_s1_hold: got %h want 02", dp_inp); end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    checks++; if (in_q.size() - ib !== 4) begin errors++; $display("FAIL bp_in_count: got %0d want 4", in_q.size() - ib); end
    checks++; if (out_q.size() - ob !== 4) begin errors++; $display("FAIL bp_out_count: got %0d want 4", out_q.size() - ob); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_at(ob + i) !== exp_v[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_at(ob + i), exp_v[i]); end
    end
  endtask

  task automatic test_len0();
    int ib, ob, db;
    logic [7:0] b;
    ib = in_q.size(); ob = out_q.size(); db = done_cnt;
    out_ready = 1'b1;
    start_frame(8'h5A, 1'b1, 4'd0);
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      feed_byte(b);
    end
    in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_17th_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    checks++; if (in_q.size() - ib !== 16) begin errors++; $display("FAIL len0_in_count: got %0d want 16", in_q.size() - ib); end
    checks++; if (out_q.size() - ob !== 16) begin errors++; $display("FAIL len0_out_count: got %0d want 16", out_q.size() - ob); end
    for (int i = 0; i < 16; i++) begin
      b = (8'h10 + 8'(i)) ^ 8'h5A;
      checks++;
      if (out_at(ob + i) !== b) begin errors++; $display("FAIL len0_data[%0d]: got %h want %h", i, out_at(ob + i), b); end
    end
    checks++;
    if (in_cyc_at(ib + 15) - in_cyc_at(ib) !== 15) begin errors++; $display("FAIL len0_rate: got %0d want 15", in_cyc_at(ib + 15) - in_cyc_at(ib)); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL len0_done_cnt: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_abort();
    int ob, db;
    ob = out_q.size(); db = done_cnt;
    out_ready = 1'b0;
    start_frame(8'h77, 1'b1, 4'd5);
    feed_byte(8'h01); feed_byte(8'h02);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== db) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, db); end
    @(posedge clk); #1;
    // abort has priority over start in IDLE
    cfg_key = 8'h99; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_prio_busy: got %b want 0", busy); end
    checks++; if (dp_key !== 8'h77) begin errors++; $display("FAIL abort_prio_key: got %h want 77", dp_key); end
    out_ready = 1'b1;
    start_frame(8'h0F, 1'b0, 4'd2);
    checks++; if (dp_key !== 8'h0F) begin errors++; $display("FAIL abort_new_key: got %h want 0f", dp_key); end
    checks++; if (dp_sel !== 1'b0) begin errors++; $display("FAIL abort_new_sel: got %b want 0", dp_sel); end
    feed_byte(8'h01); feed_byte(8'h02);
    wait_idle();
    checks++; if (out_q.size() - ob !== 2) begin errors++; $display("FAIL abort_out_count: got %0d want 2", out_q.size() - ob); end
    checks++; if (out_at(ob) !== 8'h0E) begin errors++; $display("FAIL abort_data0: got %h want 0e", out_at(ob)); end
    checks++; if (out_at(ob + 1) !== 8'h0D) begin errors++; $display("FAIL abort_data1: got %h want 0d", out_at(ob + 1)); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL abort_done_cnt: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_async_reset();
    int ob, db;
    ob = out_q.size(); db = done_cnt;
    out_ready = 1'b0;
    start_frame(8'h11, 1'b1, 4'd4);
    feed_byte(8'hAA); feed_byte(8'hBB);
    #2; rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL arst_out_data: got %h want 00", out_data); end
    checks++; if (dp_inp !== 8'h00) begin errors++; $display("FAIL arst_dp_inp: got %h want 00", dp_inp); end
    checks++; if (dp_key !== 8'h00) begin errors++; $display("FAIL arst_dp_key: got %h want 00", dp_key); end
    checks++; if (dp_sel !== 1'b0) begin errors++; $display("FAIL arst_dp_sel: got %b want 0", dp_sel); end
    #1; rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    start_frame(8'h22, 1'b0, 4'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_restart: got %b want 1", busy); end
    feed_byte(8'h5A);
    wait_idle();
    checks++; if (out_q.size() - ob !== 1) begin errors++; $display("FAIL arst_out_count: got %0d want 1", out_q.size() - ob); end
    checks++; if (out_at(ob) !== 8'h78) begin errors++; $display("FAIL arst_data: got %h want 78", out_at(ob)); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL arst_done_cnt: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_config_freeze();
    int ob;
    ob = out_q.size();
    out_ready = 1'b1;
    start_frame(8'h3C, 1'b1, 4'd3);
    feed_byte(8'h10);
    cfg_key = 8'hFF; cfg_mode = 1'b0; cfg_len = 4'd1; start = 1'b1;
    feed_byte(8'h20);
    start = 1'b0;
    checks++; if (dp_key !== 8'h3C) begin errors++; $display("FAIL freeze_key_mid: got %h want 3c", dp_key); end
    checks++; if (dp_sel !== 1'b1) begin errors++; $display("FAIL freeze_sel_mid: got %b want 1", dp_sel); end
    feed_byte(8'h30);
    wait_idle();
    checks++; if (dp_key !== 8'h3C) begin errors++; $display("FAIL freeze_key_end: got %h want 3c", dp_key); end
    checks++; if (out_q.size() - ob !== 3) begin errors++; $display("FAIL freeze_count: got %0d want 3", out_q.size() - ob); end
    checks++; if (out_at(ob) !== 8'h2C) begin errors++; $display("FAIL freeze_data0: got %h want 2c", out_at(ob)); end
    checks++; if (out_at(ob + 1) !== 8'h1C) begin errors++; $display("FAIL freeze_data1: got %h want 1c", out_at(ob + 1)); end
    checks++; if (out_at(ob + 2) !== 8'h0C) begin errors++; $display("FAIL freeze_data2: got %h want 0c", out_at(ob + 2)); end
  endtask

  task automatic test_back_to_back();
    int ob, db, t;
    ob = out_q.size(); db = done_cnt;
    out_ready = 1'b1;
    start_frame(8'h01, 1'b1, 4'd1);
    feed_byte(8'h40);
    t = 0;
    while (!done && t < 20) begin @(posedge clk); #1; t++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_seen: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_with_done: got %b want 0", busy); end
    start_frame(8'h02, 1'b0, 4'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_taken: got %b want 1", busy); end
    checks++; if (dp_key !== 8'h02) begin errors++; $display("FAIL b2b_key: got %h want 02", dp_key); end
    feed_byte(8'h50); feed_byte(8'h60);
    wait_idle();
    checks++; if (out_at(ob) !== 8'h41) begin errors++; $display("FAIL b2b_data0: got %h want 41", out_at(ob)); end
    checks++; if (out_at(ob + 1) !== 8'h52) begin errors++; $display("FAIL b2b_data1: got %h want 52", out_at(ob + 1)); end
    checks++; if (out_at(ob + 2) !== 8'h62) begin errors++; $display("FAIL b2b_data2: got %h want 62", out_at(ob + 2)); end
    checks++; if (done_cnt - db !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt - db); end
  endtask

  initial begin
    rst = 1'b1; cfg_key = 8'h00; cfg_mode = 1'b0; cfg_len = 4'd0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_abort();
    test_async_reset();
    test_config_freeze();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
